// File: rtl/ps2_rx_deserializer.sv
// PS/2 receive front end: synchronises and filters ps2c/ps2d and assembles 11-bit frames into scan codes.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity or a missing stop bit, and to flag timeouts.
module ps2_rx_deserializer #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       rx_busy,
    output logic       err_tick
);

    localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  ps2c_s1, ps2c_s2;
    logic                  ps2d_s1, ps2d_s2;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_ps2c_reg, f_ps2c_next;
    logic                  fall_edge;
    logic [3:0]            n_reg, n_next;
    logic [9:0]            sh_reg, sh_next;
    logic [TW-1:0]         t_reg, t_next;
    logic [7:0]            dout_reg;
    logic                  frame_ok;
    logic                  load_ok;
    logic                  timeout_hit;

    // Both lines idle high, so the synchronisers and filter reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1    <= 1'b1;
            ps2c_s2    <= 1'b1;
            ps2d_s1    <= 1'b1;
            ps2d_s2    <= 1'b1;
            filter_reg <= '1;
            f_ps2c_reg <= 1'b1;
        end else begin
            ps2c_s1    <= ps2c;
            ps2c_s2    <= ps2c_s1;
            ps2d_s1    <= ps2d;
            ps2d_s2    <= ps2d_s1;
            filter_reg <= {ps2c_s2, filter_reg[FILTER_LEN-1:1]};
            f_ps2c_reg <= f_ps2c_next;
        end
    end

    always_comb begin
        f_ps2c_next = f_ps2c_reg;
        if (&filter_reg) begin
            f_ps2c_next = 1'b1;
        end else if (~|filter_reg) begin
            f_ps2c_next = 1'b0;
        end
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            sh_reg    <= '0;
            t_reg     <= '0;
            dout_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            sh_reg    <= sh_next;
            t_reg     <= t_next;
            if (load_ok) begin
                dout_reg <= sh_reg[7:0];
            end
        end
    end

    // After ten shifts: sh_reg[9] = stop, sh_reg[8] = parity, sh_reg[7:0] = data.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = (^sh_reg[8:0]) & sh_reg[9];
`else
    assign frame_ok = 1'b1;
`endif

    assign timeout_hit = (state_reg == DPS) && !fall_edge && (t_reg == T_LAST);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        sh_next    = sh_reg;
        t_next     = t_reg;
        load_ok    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall_edge && rx_en && !ps2d_s2) begin
                    state_next = DPS;
                    n_next     = 4'd10;
                    t_next     = '0;
                end
            end
            DPS: begin
                if (fall_edge) begin
                    sh_next = {ps2d_s2, sh_reg[9:1]};
                    n_next  = n_reg - 4'd1;
                    t_next  = '0;
                    if (n_reg == 4'd1) begin
                        state_next = LOAD;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    t_next     = '0;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end
            LOAD: begin
                state_next = IDLE;
                load_ok    = frame_ok;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rx_done_tick is a valid-only strobe with no ready: the consumer must take dout in that
    // cycle. dout bypasses the register during LOAD so it is valid alongside the strobe.
    assign rx_done_tick = load_ok;
    assign dout         = load_ok ? sh_reg[7:0] : dout_reg;
    assign rx_busy      = (state_reg != IDLE);

`ifdef PS2_PARITY_CHECK_EN
    assign err_tick = ((state_reg == LOAD) && !frame_ok) || timeout_hit;
`else
    assign err_tick = 1'b0;
`endif

endmodule
